// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: per-channel 2-flop synchroniser, stability counter and
// rise/fall pulses, with one shared free-running tick prescaler.
module debouncer_multi #(
    parameter int CHANNELS     = 4,
    parameter int CLK_DIV      = 100000,
    parameter int STABLE_TICKS = 10,
    parameter int INIT_LEVEL   = 0,
    parameter int SIM          = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);

    localparam int P  = (SIM != 0) ? 32 : CLK_DIV;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0]       PRE_LAST = PW'(P - 1);
    localparam logic [CW-1:0]       CNT_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [CHANNELS-1:0] INIT_VEC = {CHANNELS{(INIT_LEVEL != 0)}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    logic [PW-1:0]       r_pre;
    logic [PW-1:0]       w_pre_next;
    logic                r_tick;
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;
    logic [CHANNELS-1:0] r_out;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic [CHANNELS-1:0] w_diff;
    logic [CHANNELS-1:0] w_commit;
    state_t              r_state      [CHANNELS];
    state_t              w_state_next [CHANNELS];
    logic [CW-1:0]       r_cnt        [CHANNELS];
    logic [CW-1:0]       w_cnt_next   [CHANNELS];

    assign out  = r_out;
    assign rise = r_rise;
    assign fall = r_fall;
    assign tick = r_tick;

    // Prescaler next count, wrapping at P-1
    always_comb begin
        if (r_pre == PRE_LAST) begin
            w_pre_next = '0;
        end else begin
            w_pre_next = r_pre + PW'(1);
        end
    end

    // Prescaler register; tick is registered so it is high exactly while the count is P-1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pre  <= w_pre_next;
            r_tick <= (w_pre_next == PRE_LAST);
        end
    end

    // Two-flop synchroniser for the raw pins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= INIT_VEC;
            r_sync2 <= INIT_VEC;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_diff = r_sync2 ^ r_out;

    // Per-channel next-state: equality with out always wins, so a bounce cancels a commit
    always_comb begin
        w_commit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_state_next[i] = r_state[i];
            w_cnt_next[i]   = r_cnt[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (w_diff[i]) begin
                        if (r_tick) begin
                            if (CNT_LAST == '0) begin
                                w_commit[i]     = 1'b1;
                                w_state_next[i] = ST_IDLE;
                                w_cnt_next[i]   = '0;
                            end else begin
                                w_state_next[i] = ST_CHECK;
                                w_cnt_next[i]   = CW'(1);
                            end
                        end else begin
                            w_state_next[i] = ST_CHECK;
                            w_cnt_next[i]   = '0;
                        end
                    end else begin
                        w_state_next[i] = ST_IDLE;
                        w_cnt_next[i]   = '0;
                    end
                end
                ST_CHECK: begin
                    if (!w_diff[i]) begin
                        w_state_next[i] = ST_IDLE;
                        w_cnt_next[i]   = '0;
                    end else if (r_tick) begin
                        if (r_cnt[i] == CNT_LAST) begin
                            w_commit[i]     = 1'b1;
                            w_state_next[i] = ST_IDLE;
                            w_cnt_next[i]   = '0;
                        end else begin
                            w_state_next[i] = ST_CHECK;
                            w_cnt_next[i]   = r_cnt[i] + CW'(1);
                        end
                    end else begin
                        w_state_next[i] = ST_CHECK;
                        w_cnt_next[i]   = r_cnt[i];
                    end
                end
                default: begin
                    w_state_next[i] = ST_IDLE;
                    w_cnt_next[i]   = '0;
                end
            endcase
        end
    end

    // Channel state, counters and registered level/pulse outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out  <= INIT_VEC;
            r_rise <= '0;
            r_fall <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_out  <= (r_out & ~w_commit) | (r_sync2 & w_commit);
            r_rise <= w_commit & r_sync2;
            r_fall <= w_commit & ~r_sync2;
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= w_state_next[i];
                r_cnt[i]   <= w_cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: a vector table for press/bounce/release plus
// hand sequences for tick phase, glitch, reset mid-count and INIT_LEVEL=1/STABLE_TICKS=1.
module tb_debouncer_multi;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [3:0] in_a, out_a, rise_a, fall_a;
    logic [3:0] in_b, out_b, rise_b, fall_b;
    logic       tick_a, tick_b;

    always #5 clk = ~clk;

    debouncer_multi #(.CHANNELS(4), .CLK_DIV(100000), .STABLE_TICKS(10), .INIT_LEVEL(0), .SIM(1)) u_dut_a (
        .clk(clk), .reset(rst_a), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a), .tick(tick_a));

    debouncer_multi #(.CHANNELS(4), .CLK_DIV(100000), .STABLE_TICKS(1), .INIT_LEVEL(1), .SIM(1)) u_dut_b (
        .clk(clk), .reset(rst_b), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b), .tick(tick_b));

    typedef struct {
        logic [3:0] in_v;
        int         hold;
        logic [3:0] exp_out;
        logic [3:0] exp_rise;
        logic [3:0] exp_fall;
        bit         mark;
        int         lat_bit;
    } vec_t;

    vec_t       tbl[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         anom    = 0;
    int         rcnt[4], fcnt[4], chg_cyc[4], rise_cyc[4];
    int         rcnt_b[4], fcnt_b[4];
    int         fb_cyc;
    int         tick_q[$];
    logic [3:0] prev_a, prev_b;

    function automatic vec_t mk(input logic [3:0] iv, input int h, input logic [3:0] eo,
                                input logic [3:0] er, input logic [3:0] ef, input bit m, input int lb);
        vec_t v;
        v.in_v = iv; v.hold = h; v.exp_out = eo; v.exp_rise = er; v.exp_fall = ef;
        v.mark = m; v.lat_bit = lb;
        return v;
    endfunction

    // two bits per channel: pulse count saturated at 3
    function automatic logic [7:0] pack_cnt(input int c [4]);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 4; i++) r[2*i +: 2] = (c[i] > 3) ? 2'd3 : 2'(c[i]);
        return r;
    endfunction

    function automatic logic [7:0] pack_mask(input logic [3:0] m);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 4; i++) r[2*i] = m[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            rcnt[i] = 0; fcnt[i] = 0; rcnt_b[i] = 0; fcnt_b[i] = 0;
        end
        fb_cyc = -1;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (tick_a === 1'b1) tick_q.push_back(cyc);
        for (int i = 0; i < 4; i++) begin
            if (rise_a[i] === 1'b1) begin rcnt[i]++; rise_cyc[i] = cyc; end
            if (fall_a[i] === 1'b1) fcnt[i]++;
            if (out_a[i] !== prev_a[i]) chg_cyc[i] = cyc;
            if (rise_a[i] === 1'b1 && fall_a[i] === 1'b1) anom++;
            if (rst_a === 1'b1) begin
                if (rise_a[i] !== (out_a[i] & ~prev_a[i])) anom++;
                if (fall_a[i] !== (~out_a[i] & prev_a[i])) anom++;
            end
            if (rise_b[i] === 1'b1) rcnt_b[i]++;
            if (fall_b[i] === 1'b1) begin
                fcnt_b[i]++;
                if (i == 0) fb_cyc = cyc;
            end
        end
        prev_a = out_a;
        prev_b = out_b;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        int mark, r0, rb, nb, t, tb_exp, got;

        rst_a = 1'b1; rst_b = 1'b1; in_a = 4'h0; in_b = 4'hF;
        prev_a = 4'h0; prev_b = 4'hF;
        for (int i = 0; i < 4; i++) begin chg_cyc[i] = 0; rise_cyc[i] = 0; end
        clear_counts();

        // Test table: press, bounce, release/independence
        tbl.push_back(mk(4'b0001, 400, 4'b0001, 4'b0001, 4'b0000, 1'b1, 0));
        for (int k = 1; k <= 15; k++)
            tbl.push_back(mk({2'b00, k[0], 1'b1}, 40, 4'b0001, 4'b0000, 4'b0000, (k == 15), -1));
        tbl.push_back(mk(4'b0011, 360, 4'b0011, 4'b0010, 4'b0000, 1'b0, 1));
        tbl.push_back(mk(4'b0010, 400, 4'b0010, 4'b0000, 4'b0001, 1'b1, 0));
        tbl.push_back(mk(4'b0111, 400, 4'b0111, 4'b0101, 4'b0000, 1'b1, 2));
        tbl.push_back(mk(4'b0110, 400, 4'b0110, 4'b0000, 4'b0001, 1'b1, 0));

        #2;
        rst_a = 1'b0; rst_b = 1'b0;
        run(3);
        check("reset_out_a", out_a, 4'h0);
        check("reset_pulses_a", {rise_a, fall_a, 3'b000, tick_a}, 12'h000);
        check("reset_out_b", out_b, 4'hF);
        check("reset_pulses_b", {rise_b, fall_b, 3'b000, tick_b}, 12'h000);

        // Prescaler phase after release
        rst_a = 1'b1; r0 = cyc; tick_q.delete();
        run(70);
        check("first_tick", (tick_q.size() > 0) ? tick_q[0] - r0 : -1, 31);
        check("second_tick", (tick_q.size() > 1) ? tick_q[1] - r0 : -1, 63);
        check("idle_out", out_a, 4'h0);

        mark = cyc;
        foreach (tbl[j]) begin
            clear_counts();
            in_a = tbl[j].in_v;
            if (tbl[j].mark) mark = cyc;
            run(tbl[j].hold);
            check($sformatf("vec%0d_out", j), out_a, tbl[j].exp_out);
            check($sformatf("vec%0d_rise", j), pack_cnt(rcnt), pack_mask(tbl[j].exp_rise));
            check($sformatf("vec%0d_fall", j), pack_cnt(fcnt), pack_mask(tbl[j].exp_fall));
            if (tbl[j].lat_bit >= 0)
                check_range($sformatf("vec%0d_latency", j), chg_cyc[tbl[j].lat_bit] - mark, 290, 322);
        end
        check("simultaneous_rise_0_2", rise_cyc[0] - rise_cyc[2], 0);

        // Short glitch on in[3] straddling a tick, then a full press to prove the count cleared
        got = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
            step();
            got = (tick_a === 1'b1) ? 1 : 0;
        end
        check("glitch_tick_found", got, 1);
        t = cyc;
        clear_counts();
        run(28);
        in_a = 4'b1110;
        run(5);
        in_a = 4'b0110;
        run(20);
        check("glitch_out", out_a, 4'b0110);
        check("glitch_rise", pack_cnt(rcnt), 8'h00);
        in_a = 4'b1110; mark = cyc;
        run(400);
        check("after_glitch_latency", chg_cyc[3] - mark, 300);
        check("after_glitch_out", out_a, 4'b1110);
        check("after_glitch_rise", pack_cnt(rcnt), pack_mask(4'b1000));

        // Reset in the middle of counting in[0]
        in_a = 4'b1111;
        run(170);
        rst_a = 1'b0;
        #1;
        check("async_reset_out", out_a, 4'h0);
        check("async_reset_pulses", {rise_a, fall_a, 3'b000, tick_a}, 12'h000);
        run(3);
        check("held_reset_out", out_a, 4'h0);
        clear_counts();
        rst_a = 1'b1; mark = cyc;
        run(400);
        check("post_reset_latency", chg_cyc[0] - mark, 320);
        check("post_reset_out", out_a, 4'b1111);
        check("post_reset_rise", pack_cnt(rcnt), pack_mask(4'b1111));
        check("post_reset_fall", pack_cnt(fcnt), 8'h00);

        // INIT_LEVEL=1, STABLE_TICKS=1 instance
        clear_counts();
        rst_b = 1'b1; rb = cyc;
        run(100);
        check("b_out_after_release", out_b, 4'hF);
        check("b_no_pulses", {pack_cnt(rcnt_b), pack_cnt(fcnt_b)}, 16'h0000);
        in_b = 4'b1110; nb = cyc;
        tb_exp = rb + 31;
        while (tb_exp < nb + 2) tb_exp += 32;
        run(70);
        check("b_fall_cycle", fb_cyc - rb, tb_exp + 1 - rb);
        check("b_fall_count", pack_cnt(fcnt_b), pack_mask(4'b0001));
        check("b_rise_count", pack_cnt(rcnt_b), 8'h00);
        check("b_out_final", out_b, 4'b1110);

        check("pulse_consistency", anom, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
